sum_n_requester: RTL and testbench

- Initiator side of the sum_N request/acknowledge protocol.
- Accepts N values from an upstream producer into a small FIFO and issues them one at a time to the sum_N responder as an N / N_valid pulse.
- Waits for sum_valid, captures and checks sum_out against N*(N+1)/2, then acknowledges with a one-cycle sum_ack.
- Reports each completed transaction upstream and counts mismatches and timeouts.

---
 rtl/sum_n_requester_if.sv | 21 ++
 rtl/sum_n_requester.sv | 113 +++++++++++
 tb/tb_sum_n_requester.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sum_n_requester_if.sv
// sum_n_requester_if: upstream request, responder handshake and result signals of sum_n_requester
interface sum_n_requester_if #(
  parameter int N_WIDTH = 3,
  parameter int SUM_WIDTH = 5
);
  logic [N_WIDTH-1:0] req_n, N, res_n;
  logic [SUM_WIDTH-1:0] sum_in, res_sum;
  logic [7:0] err_count;
  logic req_valid, req_ready, N_valid, sum_valid, sum_ack;
  logic res_valid, res_err, res_timeout, busy;
  modport master (
    input req_n, req_valid, sum_in, sum_valid,
    output req_ready, N, N_valid, sum_ack, res_valid, res_n, res_sum, res_err, res_timeout,
    err_count, busy
  );
  modport slave (
    output req_n, req_valid, sum_in, sum_valid,
    input req_ready, N, N_valid, sum_ack, res_valid, res_n, res_sum, res_err, res_timeout,
    err_count, busy
  );
endinterface

// File: rtl/sum_n_requester.sv
// sum_n_requester: FIFO-buffered initiator that issues N to a sum_N responder and checks the returned sum
module sum_n_requester #(
  parameter int N_WIDTH = 3,
  parameter int SUM_WIDTH = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_DELAY = 0,
  parameter int TIMEOUT = 63
) (
  input logic clk,
  input logic reset,
  sum_n_requester_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2((TIMEOUT > ACK_DELAY ? TIMEOUT : ACK_DELAY) + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] A_LAST = TW'(ACK_DELAY > 0 ? ACK_DELAY - 1 : 0);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_SUM, ACK_WAIT, ACK, RELEASE, DONE} state_t;
  state_t state;
  logic [N_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [N_WIDTH-1:0] n_reg;
  logic [SUM_WIDTH-1:0] sum_reg, expected;
  logic [TW-1:0] timer;
  logic push, pop, zero, fin, fin_to, err;
  assign bus.req_ready = count != CW'(FIFO_DEPTH);
  assign bus.busy = state != IDLE || count != '0;
  assign bus.N = n_reg;
  assign push = bus.req_valid && bus.req_ready;
  assign pop = state == IDLE && count != '0;
  assign zero = pop && mem[rd_ptr] == '0;
  assign expected = SUM_WIDTH'((int'(n_reg) * (int'(n_reg) + 1)) / 2);
  assign fin_to = timer == T_LAST && (state == WAIT_SUM && !bus.sum_valid || state == RELEASE && bus.sum_valid);
  assign fin = fin_to || zero || state == RELEASE && !bus.sum_valid;
  assign err = fin_to || !zero && sum_reg != expected;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.req_n;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Outputs are registered on entry to the state in which they are visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      n_reg <= '0;
      sum_reg <= '0;
      timer <= '0;
      bus.N_valid <= 1'b0;
      bus.sum_ack <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_n <= '0;
      bus.res_sum <= '0;
      bus.res_err <= 1'b0;
      bus.res_timeout <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.N_valid <= 1'b0;
      bus.sum_ack <= 1'b0;
      bus.res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) n_reg <= mem[rd_ptr];
          if (pop && !zero) begin
            state <= ISSUE;
            bus.N_valid <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_SUM;
          timer <= '0;
        end
        WAIT_SUM: begin
          timer <= bus.sum_valid ? '0 : timer + TW'(1);
          if (bus.sum_valid) begin
            sum_reg <= bus.sum_in;
            state <= ACK_DELAY == 0 ? ACK : ACK_WAIT;
            bus.sum_ack <= ACK_DELAY == 0;
          end
        end
        ACK_WAIT: begin
          timer <= timer == A_LAST ? '0 : timer + TW'(1);
          if (timer == A_LAST) begin
            state <= ACK;
            bus.sum_ack <= 1'b1;
          end
        end
        ACK: state <= RELEASE;
        RELEASE: timer <= timer + TW'(1);
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fin) begin
        state <= DONE;
        bus.res_valid <= 1'b1;
        bus.res_n <= zero ? '0 : n_reg;
        bus.res_sum <= zero || fin_to ? '0 : sum_reg;
        bus.res_err <= err;
        bus.res_timeout <= fin_to;
        if (err && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_sum_n_requester.sv
// tb_sum_n_requester: directed and randomized checks of sum_n_requester against sum_N responder models
module tb_sum_n_requester;
  typedef struct {int n; int s; int e; int t; int cyc;} res_t;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, failures = 0, cycle = 0, pc = 0;
  int silent = 0, corrupt = 0, lat_max = 0;
  int nv0 = 0, nv0_cyc = 0, last_n0 = 0, ack0 = 0, ack0_cyc = 0, low0 = 0;
  int nv1 = 0, nv1_cyc = 0, ack1 = 0, ack1_cyc = 0;
  res_t r0_q[$], r1_q[$], rm0, rm1, rr;
  int exp_q[$];
  sum_n_requester_if #(.N_WIDTH(3), .SUM_WIDTH(5)) b0();
  sum_n_requester_if #(.N_WIDTH(3), .SUM_WIDTH(5)) b1();
  sum_n_requester #(.ACK_DELAY(0)) u0 (.clk(clk), .reset(reset), .bus(b0.master));
  sum_n_requester #(.ACK_DELAY(3)) u1 (.clk(clk), .reset(reset), .bus(b1.master));
  always #5 clk = ~clk;
  function automatic int exp_sum(input int n);
    return (n * (n + 1) / 2) % 32;
  endfunction
  always @(negedge clk) begin
    cycle++;
    if (!b0.req_ready) low0++;
    if (b0.N_valid) begin nv0++; nv0_cyc = cycle; last_n0 = int'(b0.N); end
    if (b0.sum_ack) begin ack0++; ack0_cyc = cycle; end
    if (b1.N_valid) begin nv1++; nv1_cyc = cycle; end
    if (b1.sum_ack) begin ack1++; ack1_cyc = cycle; end
    if (b0.res_valid) begin
      rm0.n = int'(b0.res_n); rm0.s = int'(b0.res_sum); rm0.e = int'(b0.res_err);
      rm0.t = int'(b0.res_timeout); rm0.cyc = cycle; r0_q.push_back(rm0);
    end
    if (b1.res_valid) begin
      rm1.n = int'(b1.res_n); rm1.s = int'(b1.res_sum); rm1.e = int'(b1.res_err);
      rm1.t = int'(b1.res_timeout); rm1.cyc = cycle; r1_q.push_back(rm1);
    end
  end
  initial begin : resp0
    int n, g;
    b0.sum_valid = 1'b0; b0.sum_in = '0;
    forever begin
      @(posedge clk); #1;
      if (b0.N_valid && silent == 0) begin
        n = int'(b0.N);
        repeat ($urandom_range(0, lat_max) + 1) @(posedge clk);
        #1;
        b0.sum_in = 5'(n * (n + 1) / 2 + corrupt);
        b0.sum_valid = 1'b1;
        g = 0;
        while (!b0.sum_ack && g < 200) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        b0.sum_valid = 1'b0;
      end
    end
  end
  initial begin : resp1
    int n, g;
    b1.sum_valid = 1'b0; b1.sum_in = '0;
    forever begin
      @(posedge clk); #1;
      if (b1.N_valid) begin
        n = int'(b1.N);
        @(posedge clk); #1;
        b1.sum_in = 5'(n * (n + 1) / 2);
        b1.sum_valid = 1'b1;
        g = 0;
        while (!b1.sum_ack && g < 200) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        b1.sum_valid = 1'b0;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic push(input int sel, input int n);
    int g = 0;
    logic rdy;
    if (sel == 0) begin b0.req_valid = 1'b1; b0.req_n = 3'(n); end
    else begin b1.req_valid = 1'b1; b1.req_n = 3'(n); end
    do begin
      rdy = sel == 0 ? b0.req_ready : b1.req_ready;
      pc = cycle + 1;
      @(posedge clk); #1;
      g++;
    end while (!rdy && g < 300);
    b0.req_valid = 1'b0;
    b1.req_valid = 1'b0;
    chk("push_accepted", 32'(rdy), 1);
  endtask
  task automatic wait_res(input int sel, input int want, input string tag);
    int g = 0;
    while ((sel == 0 ? r0_q.size() : r1_q.size()) < want && g < 2000) begin @(posedge clk); #1; g++; end
    chk(tag, sel == 0 ? r0_q.size() : r1_q.size(), want);
  endtask
  task automatic wait_nv0(input int from);
    int g = 0;
    while (nv0 == from && g < 100) begin @(posedge clk); #1; g++; end
    chk("nv_seen", nv0, from + 1);
  endtask
  task automatic chk_res(input string tag, input res_t r, input int n, input int s, input int e, input int t);
    chk({tag, "_n"}, r.n, n);
    chk({tag, "_sum"}, r.s, s);
    chk({tag, "_err"}, r.e, e);
    chk({tag, "_timeout"}, r.t, t);
  endtask
  initial begin
    int base, nvb, ackb, tnv;
    int seq[5] = '{3, 5, 1, 0, 6};
    b0.req_valid = 1'b0; b0.req_n = '0;
    b1.req_valid = 1'b0; b1.req_n = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", b0.req_ready, 1);
    chk("rst_outputs", {b0.N, b0.N_valid, b0.sum_ack, b0.res_valid, b0.res_n, b0.res_sum, b0.res_err, b0.res_timeout}, 0);
    chk("rst_err_count", b0.err_count, 0);
    chk("rst_busy", {b0.busy, b1.busy}, 0);
    reset = 1'b0;
    push(0, 7);
    wait_res(0, 1, "t1_count");
    chk_res("t1", r0_q[0], 7, 28, 0, 0);
    chk("t1_nvalid_lat", nv0_cyc - pc, 2);
    chk("t1_nvalue", last_n0, 7);
    chk("t1_ack_lat", ack0_cyc - pc, 4);
    chk("t1_res_lat", r0_q[0].cyc - pc, 6);
    chk("t1_ack_count", ack0, 1);
    base = r0_q.size(); nvb = nv0;
    foreach (seq[i]) push(0, seq[i]);
    wait_res(0, base + 5, "t2_count");
    foreach (seq[i]) chk_res("t2", r0_q[base + i], seq[i], exp_sum(seq[i]), 0, 0);
    chk("t2_nvalid_count", nv0 - nvb, 4);
    chk("t2_full_seen", 32'(low0 > 0), 1);
    chk("t2_err_count", b0.err_count, 0);
    base = r0_q.size(); ackb = ack0; corrupt = -1;
    push(0, 7);
    wait_res(0, base + 1, "t3_count");
    chk_res("t3", r0_q[base], 7, 27, 1, 0);
    @(posedge clk); #1;
    chk("t3_err_count", b0.err_count, 1);
    chk("t3_ack_count", ack0 - ackb, 1);
    corrupt = 0; base = r0_q.size(); silent = 1; nvb = nv0;
    push(0, 7);
    push(0, 3);
    wait_nv0(nvb);
    tnv = nv0_cyc;
    silent = 0;
    wait_res(0, base + 2, "t4_count");
    chk_res("t4_to", r0_q[base], 7, 0, 1, 1);
    chk("t4_to_lat", r0_q[base].cyc - tnv, 64);
    chk_res("t4_next", r0_q[base + 1], 3, 6, 0, 0);
    chk("t4_err_count", b0.err_count, 2);
    silent = 1; nvb = nv0;
    push(0, 4);
    wait_nv0(nvb);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_outputs", {b0.N, b0.N_valid, b0.sum_ack, b0.res_valid, b0.res_sum, b0.res_err, b0.res_timeout}, 0);
    chk("t5_err_count", b0.err_count, 0);
    chk("t5_ready_busy", {b0.req_ready, b0.busy}, 2'b10);
    silent = 0; base = r0_q.size();
    push(0, 2);
    wait_res(0, base + 1, "t5_count");
    chk_res("t5", r0_q[base], 2, 3, 0, 0);
    base = r0_q.size(); lat_max = 4;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back($urandom_range(0, 7));
      push(0, exp_q[i]);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_res(0, base + 16, "rand_count");
    for (int i = 0; i < 16; i++) chk_res("rand", r0_q[base + i], exp_q[i], exp_sum(exp_q[i]), 0, 0);
    chk("rand_err_count", b0.err_count, 0);
    lat_max = 0;
    push(1, 5);
    wait_res(1, 1, "t6_count");
    chk_res("t6", r1_q[0], 5, 15, 0, 0);
    chk("t6_ack_lat", ack1_cyc - nv1_cyc, 5);
    chk("t6_ack_count", ack1, 1);
    chk("t6_nvalid_count", nv1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
